// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 ops, FSM states, instruction IDs.
// Holds no logic. The helper functions classify which operands an op treats as signed.
package muldiv_pkg;

    localparam int GPR_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Decoder-facing IDs for the M-extension instructions (OP opcode, funct7 = 0000001)
    typedef enum logic [3:0] {
        INSN_NONE   = 4'd0,
        INSN_MUL    = 4'd1,
        INSN_MULH   = 4'd2,
        INSN_MULHSU = 4'd3,
        INSN_MULHU  = 4'd4,
        INSN_DIV    = 4'd5,
        INSN_DIVU   = 4'd6,
        INSN_REM    = 4'd7,
        INSN_REMU   = 4'd8
    } muldiv_insn_e;

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step ({hi,lo} >> 1 after conditional add)
// or restoring shift-subtract divide step (remainder in hi, quotient bits shifted into lo).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = GPR_WIDTH
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + ({(XLEN+1){lo[0]}} & {1'b0, opb});
        // Extra top bit catches the borrow when the shifted remainder is below the divisor
        diff = {1'b0, hi, lo[XLEN-1]} - {2'b00, opb};
        if (is_div) begin
            hi_nxt = diff[XLEN+1] ? {hi[XLEN-2:0], lo[XLEN-1]} : diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ~diff[XLEN+1]};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M mul/div: 32 CALC cycles (done_o at k+33); div-by-zero/overflow finish at k+1,
// as do MUL* when MULDIV_FAST_MUL_EN is defined. stall_o holds the pipe until DONE; flush_i aborts.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = GPR_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    muldiv_state_e     state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    muldiv_op_e        op_q;
    logic              sign_a_q, neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, opb_q, result_q;
    logic [XLEN-1:0]   hi_step, lo_step, fixed_res;
    logic [XLEN-1:0]   mag_a, mag_b, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod_fix;
    logic              accept, last_iter, skip_calc;
    logic              sign_a, sign_b, div_zero, div_ovf;

    always_comb begin
        sign_a   = op_a_signed(op_i) & rs1_val_i[XLEN-1];
        sign_b   = op_b_signed(op_i) & rs2_val_i[XLEN-1];
        mag_a    = sign_a ? -rs1_val_i : rs1_val_i;
        mag_b    = sign_b ? -rs2_val_i : rs2_val_i;
        div_zero = op_i[2] && (rs2_val_i == '0);
        div_ovf  = op_i[2] && op_b_signed(op_i) && (rs1_val_i == XMIN) && (rs2_val_i == '1);
`ifdef MULDIV_FAST_MUL_EN
        skip_calc = div_zero | div_ovf | ~op_i[2];
`else
        skip_calc = div_zero | div_ovf;
`endif
    end

    assign last_iter = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        busy_o    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    accept    = 1'b1;
                    stall_o   = 1'b1;
                    state_nxt = skip_calc ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stall_o = 1'b1;
                if (last_iter) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o    = !flush_i;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i)          cnt_q <= '0;
        else if (state_q == ST_CALC) cnt_q <= last_iter ? '0 : cnt_q + CNT_W'(1);
    end

    // Multiply: lo holds the multiplier, opb the multiplicand. Divide: lo the dividend, opb the divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= muldiv_op_e'(op_i);
                opb_q    <= op_i[2] ? mag_b : mag_a;
                hi_q     <= '0;
                lo_q     <= op_i[2] ? mag_a : mag_b;
                sign_a_q <= sign_a;
                neg_q    <= sign_a ^ sign_b;
                if (div_zero) begin
                    hi_q     <= rs1_val_i;
                    lo_q     <= '1;
                    sign_a_q <= 1'b0;
                    neg_q    <= 1'b0;
                end else if (div_ovf) begin
                    lo_q     <= XMIN;
                    sign_a_q <= 1'b0;
                    neg_q    <= 1'b0;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (!op_i[2]) begin
                    {hi_q, lo_q} <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
                end
`endif
            end else if (state_q == ST_CALC && !flush_i) begin
                hi_q <= hi_step;
                lo_q <= lo_step;
            end
            if (state_q == ST_DONE && !flush_i) result_q <= fixed_res;
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (op_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .opb    (opb_q),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = sign_a_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       fixed_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixed_res = quo_fix;
            default:                      fixed_res = rem_fix;
        endcase
    end

    assign result_o = (state_q == ST_DONE && !flush_i) ? fixed_res : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq: results via an expected-value queue, latency,
// stall/busy/done timing, flush abort, flush-over-start priority and reset mid-operation.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1_val, rs2_val, result;
    logic        stall, busy, done;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .op_i      (op),
        .rs1_val_i (rs1_val),
        .rs2_val_i (rs2_val),
        .flush_i   (flush),
        .stall_o   (stall),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf)        return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf)        return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        int          cyc;
        bit          seen, stall_ok;
        logic        stall_at_done;
        logic [31:0] exp;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs1_val = a;
        rs2_val = b;
        exp_q.push_back(exp_res);
        #1;
        stall_ok = (stall === 1'b1);
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        stall_at_done = 1'b1;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
                stall_at_done = stall;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        exp = exp_q.pop_front();
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " stall profile"}, {30'd0, stall_ok, stall_at_done}, 32'd2);
        check({tag, " result"}, result, exp);
        last_res = exp;
        @(negedge clk);
        #1;
        check({tag, " idle after done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        bit          saw;

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0;
        last_res = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset result", result, 32'd0);
        check("reset flags", {29'd0, done, busy, stall}, 32'd0);

        run_op("MUL",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("MULHU",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("MULH",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("MULHSU",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("DIV",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("REM",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("DIVU",    3'd5, 32'd100,       32'd7,        32'd14,        33);
        run_op("REMU",    3'd7, 32'd100,       32'd7,        32'd2,         33);
        run_op("DIVU/0",  3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1);
        run_op("REMU/0",  3'd7, 32'd5,         32'd0,        32'd5,         1);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Flush a DIVU during cycle k+10, then start a fresh op at k+12
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3;
        @(posedge clk);
        saw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) saw = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        if (done === 1'b1) saw = 1'b1;
        check("flush busy low", 32'(busy), 32'd0);
        check("flush no done", 32'(saw), 32'd0);
        check("flush result kept", result, last_res);
        run_op("after flush", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        // flush_i wins over start_i in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd5; rs1_val = 32'd9; rs2_val = 32'd2;
        #1;
        check("flush+start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush+start busy", 32'(busy), 32'd0);

        // Reset mid-CALC aborts without done_o
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs1_val = 32'd77; rs2_val = 32'd5;
        @(posedge clk);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done === 1'b1) saw = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) saw = 1'b1;
        end
        check("reset abort no done", 32'(saw), 32'd0);
        check("reset abort result", result, 32'd0);
        check("reset abort busy", 32'(busy), 32'd0);
        last_res = 32'd0;

        for (int n = 0; n < 8; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            run_op("random", ro, ra, rb, model(ro, ra, rb), lat_of(ro, ra, rb));
        end

        check("queue drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32 (`GPR_WIDTH), operand/result width.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request pulse from EXE for an M-extension instruction.
REQ-006 SHALL have port op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port rs1_val_i  input  XLEN  operand A (multiplicand/dividend), forwarded value.
REQ-008 SHALL have port rs2_val_i  input  XLEN  operand B (multiplier/divisor), forwarded value.
REQ-009 SHALL have port flush_i  input  1  abort current operation (branch/trap flush).
REQ-010 SHALL have port stall_o  output  1  hold IF/ID/ID_EXE; EXE result not ready.
REQ-011 SHALL have port busy_o  output  1  state is not IDLE.
REQ-012 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.
REQ-013 SHALL have port result_o  output  XLEN  operation result, held until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; the state register is the only control state besides the counter.
REQ-015 SHALL accept start_i only in IDLE with flush_i=0; start_i in CALC/DONE is ignored.
REQ-016 SHALL, on accept at edge k, latch op and operands, converting signed operands to magnitudes (signed: DIV, REM, MULH both; MULHSU rs1 only).
REQ-017 SHALL run CALC for exactly 32 cycles (counter 0..31, wrap to 0 on exit), DONE at cycle k+33, IDLE at k+34.
REQ-018 SHALL multiply by shift-add, one multiplier bit per cycle, into a 2*XLEN product register.
REQ-019 SHALL divide by restoring shift-subtract, one quotient bit per cycle, with XLEN-bit remainder and quotient registers.
REQ-020 SHALL apply sign fix in DONE: product negated if sign A xor sign B; quotient negated if sign A xor sign B; remainder takes sign of A.
REQ-021 SHALL select result: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-022 SHALL on divisor zero skip CALC (DONE at k+1): quotient all ones, remainder = rs1_val_i unchanged.
REQ-023 SHALL on DIV/REM with A=0x80000000, B=0xFFFFFFFF skip CALC: quotient 0x80000000, remainder 0.
REQ-024 SHALL drive stall_o = (IDLE & start_i & ~flush_i) | CALC; stall_o SHALL be 0 in DONE.
REQ-025 SHALL assert done_o only in DONE, exactly one cycle per accepted, non-flushed operation.
REQ-026 SHALL on flush_i=1 in any state go to IDLE next edge, clear counter, suppress done_o, keep result_o unchanged.
REQ-027 SHALL give flush_i priority over start_i when both are asserted in IDLE.

Reset
REQ-028 SHALL on rst=1 at a clock edge set state IDLE, counter 0, result_o 0, done_o 0, busy_o 0, stall_o 0.
REQ-029 SHALL let rst mid-CALC abort the operation with no done_o pulse.
REQ-030 SHALL give rst priority over flush_i and start_i.

Configuration
REQ-031 SHALL honour macro MULDIV_FAST_MUL_EN: defined -> MUL* computed by one combinational XLEN x XLEN multiply, DONE at k+1.
REQ-032 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiplier (DONE at k+33); division SHALL be iterative in both builds.

Structure
REQ-033 SHALL place the funct3 op encodings, the FSM state encodings and the M-extension instruction IDs in the shared defines header/package.
REQ-034 SHALL contain one sub-module muldiv_step: a combinational single iteration (add-shift or subtract-shift), instanced once.

Verification
REQ-035 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done_o at k+33 (k+1 with MULDIV_FAST_MUL_EN), stall_o high k..k+32.
REQ-036 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-037 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
REQ-038 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done_o at k+1.
REQ-039 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with done_o at k+1.
REQ-040 SHALL cover flush_i at k+10 of a DIVU -> no done_o, busy_o low at k+11; a new start at k+12 completes correctly.
